// File: rtl/instruction_assembler_pkg.sv
// Shared definitions for the MIPS instruction assembler (and decoder):
// opcode constants, format enum, field bit positions, assembler FSM states.
package instruction_assembler_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    typedef enum logic [1:0] {
        FMT_R,
        FMT_I,
        FMT_J
    } fmt_e;

    // Least-significant bit position of each field in a 32-bit instruction word
    localparam int unsigned OPP_LSB   = 26;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned SHAMT_LSB = 6;
    localparam int unsigned FUNC_LSB  = 0;
    localparam int unsigned IMM_LSB   = 0;
    localparam int unsigned JADDR_LSB = 0;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } asm_state_e;

    // Instruction format implied by the opcode
    function automatic fmt_e fmt_of(input logic [5:0] opp);
        if (opp == OP_RTYPE) begin
            return FMT_R;
        end else if ((opp == OP_J) || (opp == OP_JAL)) begin
            return FMT_J;
        end else begin
            return FMT_I;
        end
    endfunction

endpackage

// File: rtl/instruction_assembler_instr_pack.sv
// instr_pack: combinational format selection and field packing of a
// decoded MIPS field bundle into a 32-bit instruction word.
module instr_pack
    import instruction_assembler_pkg::*;
(
    input  logic [5:0]  opp,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  func,
    input  logic [15:0] imm,
    input  logic [25:0] jaddress,
    output logic [31:0] word
);

    fmt_e fmt;

    // Select the format from the opcode and place only the fields it uses
    always_comb begin
        fmt  = fmt_of(opp);
        word = '0;
        word[OPP_LSB +: 6] = opp;
        case (fmt)
            FMT_R: begin
                word[RS_LSB +: 5]    = rs;
                word[RT_LSB +: 5]    = rt;
                word[RD_LSB +: 5]    = rd;
                word[SHAMT_LSB +: 5] = shamt;
                word[FUNC_LSB +: 6]  = func;
            end
            FMT_J: begin
                word[JADDR_LSB +: 26] = jaddress;
            end
            default: begin
                word[RS_LSB +: 5]   = rs;
                word[RT_LSB +: 5]   = rt;
                word[IMM_LSB +: 16] = imm;
            end
        endcase
    end

endmodule

// File: rtl/instruction_assembler.sv
// instruction_assembler: accepts decoded MIPS field bundles over valid/ready,
// packs them into 32-bit words and writes each to instruction memory through
// a single-outstanding write port with acknowledge.
// Optional feature macro: INSTR_ASSEMBLER_CHECKSUM_EN (running XOR checksum of
// written words; when undefined the checksum port is tied to zero).
module instruction_assembler
    import instruction_assembler_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        Opp,
    input  logic [4:0]        Rs,
    input  logic [4:0]        Rt,
    input  logic [4:0]        Rd,
    input  logic [4:0]        Shamt,
    input  logic [5:0]        Func,
    input  logic [15:0]       Imm,
    input  logic [25:0]       Jaddress,
    input  logic              load_addr,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  word_count,
    output logic [31:0]       checksum
);

    asm_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       packed_word;
    logic [ADDR_W-1:0] start_aligned;

    assign start_aligned = start_addr & ~ADDR_W'(3);

    instr_pack u_pack (
        .opp      (Opp),
        .rs       (Rs),
        .rt       (Rt),
        .rd       (Rd),
        .shamt    (Shamt),
        .func     (Func),
        .imm      (Imm),
        .jaddress (Jaddress),
        .word     (packed_word)
    );

`ifdef INSTR_ASSEMBLER_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;

    // Checksum register: XOR of every acknowledged word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    // Fold the outstanding word in on acknowledge
    always_comb begin
        csum_d = csum_q;
        if ((state_q == ST_ISSUE) && mem_ack) begin
            csum_d = csum_q ^ data_q;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    // State, pointer, pending write and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        count_d  = count_q;
        in_ready = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (load_addr) begin
                    ptr_d = start_aligned;
                end
                if (in_valid) begin
                    addr_d  = load_addr ? start_aligned : ptr_q;
                    data_d  = packed_word;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_we = 1'b1;
                if (mem_ack) begin
                    ptr_d   = addr_q + ADDR_W'(4);
                    count_d = count_q + CNT_W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign word_count = count_q;

endmodule
